// File: rtl/present_core_if.sv
// Register-slave to PRESENT core connection: start/key/plaintext down, result and status up.
interface present_core_if #(
    parameter int unsigned KEY_WIDTH = 80
);
    logic                 start;
    logic [KEY_WIDTH-1:0] key;
    logic [63:0]          plaintext;
    logic [63:0]          ciphertext;
    logic                 busy;
    logic                 done;
    logic                 trigger;

    modport master (
        output start, key, plaintext,
        input  ciphertext, busy, done, trigger
    );

    modport slave (
        input  start, key, plaintext,
        output ciphertext, busy, done, trigger
    );
endinterface

// File: rtl/present_core.sv
// Iterative PRESENT encryption core: one round per clock, 80- or 128-bit key,
// 32 cycles from accepted start to done.
module present_core #(
    parameter int unsigned KEY_WIDTH = 80
) (
    input logic           clock,
    input logic           reset,
    present_core_if.slave bus
);
    localparam int unsigned BLK_W = 64;
    localparam int unsigned CNT_W = 5;

    if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_width
        $error("present_core: KEY_WIDTH must be 80 or 128");
    end

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_e;

    fsm_e                 fsm_q, fsm_d;
    logic [BLK_W-1:0]     state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BLK_W-1:0]     ct_q, ct_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 trig_q, trig_d;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [BLK_W-1:0] s_layer(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Bit i lands at (16*i) mod 63; bit 63 is a fixed point.
    function automatic logic [BLK_W-1:0] p_layer(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        logic [5:0]       j;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            j    = 6'((16 * i) % 63);
            y[j] = x[i];
        end
        y[63] = x[63];
        return y;
    endfunction

    logic [BLK_W-1:0]     round_out;
    logic [KEY_WIDTH-1:0] key_rot;
    logic [KEY_WIDTH-1:0] key_upd;

    assign round_out = p_layer(s_layer(state_q ^ key_q[KEY_WIDTH-1 -: BLK_W]));
    assign key_rot   = {key_q[KEY_WIDTH-62:0], key_q[KEY_WIDTH-1:KEY_WIDTH-61]};

    if (KEY_WIDTH == 80) begin : g_ks80
        always_comb begin
            key_upd          = key_rot;
            key_upd[79:76]   = sbox(key_rot[79:76]);
            key_upd[19:15]   = key_rot[19:15] ^ cnt_q;
        end
    end else begin : g_ks128
        always_comb begin
            key_upd          = key_rot;
            key_upd[127:124] = sbox(key_rot[127:124]);
            key_upd[123:120] = sbox(key_rot[123:120]);
            key_upd[66:62]   = key_rot[66:62] ^ cnt_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            ct_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            ct_q    <= ct_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            trig_q  <= trig_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        ct_d    = ct_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        trig_d  = trig_q;
        case (fsm_q)
            IDLE: begin
                if (bus.start) begin
                    fsm_d   = ROUND;
                    state_d = bus.plaintext;
                    key_d   = bus.key;
                    cnt_d   = CNT_W'(1);
                    busy_d  = 1'b1;
                    trig_d  = 1'b1;
                end
            end
            ROUND: begin
                state_d = round_out;
                key_d   = key_upd;
                // Counter parks at 31 rather than wrapping into FINAL.
                if (cnt_q == CNT_W'(31)) begin
                    fsm_d = FINAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FINAL: begin
                fsm_d  = IDLE;
                ct_d   = state_q ^ key_q[KEY_WIDTH-1 -: BLK_W];
                done_d = 1'b1;
                busy_d = 1'b0;
                trig_d = 1'b0;
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign bus.ciphertext = ct_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.trigger    = trig_q;
endmodule

// File: tb/tb_present_core.sv
// Self-checking bench for present_core: known-answer table, random vectors
// against a bit-level reference model, and multi-cycle control corner cases.
module tb_present_core;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    present_core_if #(.KEY_WIDTH(80))  if80();
    present_core_if #(.KEY_WIDTH(128)) if128();

    present_core #(.KEY_WIDTH(80))  dut80  (.clock(clock), .reset(reset), .bus(if80.slave));
    present_core #(.KEY_WIDTH(128)) dut128 (.clock(clock), .reset(reset), .bus(if128.slave));

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        int           kw;
        logic [127:0] key;
        logic [63:0]  pt;
        logic [63:0]  exp;
    } vec_t;

    localparam logic [127:0] K80_ONES = {48'h0, 80'hFFFF_FFFF_FFFF_FFFF_FFFF};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int kw, input logic s, input logic [127:0] k, input logic [63:0] p);
        if (kw == 80) begin
            if80.start = s; if80.key = k[79:0]; if80.plaintext = p;
        end else begin
            if128.start = s; if128.key = k; if128.plaintext = p;
        end
    endtask

    task automatic sample(input int kw, output logic [63:0] ct, output logic b, output logic d, output logic t);
        if (kw == 80) begin
            ct = if80.ciphertext; b = if80.busy; d = if80.done; t = if80.trigger;
        end else begin
            ct = if128.ciphertext; b = if128.busy; d = if128.done; t = if128.trigger;
        end
    endtask

    // Reference: PRESENT written directly from the cipher definition, one bit at a time.
    function automatic logic [63:0] model(input int kw, input logic [127:0] key_in, input logic [63:0] pt);
        logic [3:0]   sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                  4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        logic [127:0] k, nk;
        logic [63:0]  s, t;
        k = key_in;
        if (kw == 80) k[127:80] = '0;
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ 64'(k >> (kw - 64));
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sb[s[4*n +: 4]];
            t = '0;
            for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (16 * i) % 63] = s[i];
            s = t;
            nk = '0;
            for (int i = 0; i < kw; i++) nk[(i + 61) % kw] = k[i];
            k = nk;
            k[kw-1 -: 4] = sb[k[kw-1 -: 4]];
            if (kw == 128) k[kw-5 -: 4] = sb[k[kw-5 -: 4]];
            k = k ^ (128'(r) << ((kw == 80) ? 15 : 62));
        end
        return s ^ 64'(k >> (kw - 64));
    endfunction

    // Single start pulse; checks latency, busy width, trigger==busy, done/busy exclusivity.
    task automatic run_one(input string name, input int kw, input logic [127:0] k,
                           input logic [63:0] p, input logic [63:0] exp);
        int          cyc, busy_n;
        logic [63:0] ct;
        logic        b, d, t, seen, bad;
        drive(kw, 1'b1, k, p);
        tick();
        drive(kw, 1'b0, ~k, ~p);
        cyc = 0; busy_n = 0; seen = 1'b0; bad = 1'b0;
        sample(kw, ct, b, d, t);
        if (b) busy_n++;
        if ((d && b) || (t !== b)) bad = 1'b1;
        while (!seen && cyc < 100) begin
            tick();
            cyc++;
            sample(kw, ct, b, d, t);
            if (d) seen = 1'b1;
            if (b) busy_n++;
            if ((d && b) || (t !== b)) bad = 1'b1;
        end
        check({name, " latency"}, 64'(cyc), 64'd32);
        check({name, " busy_cycles"}, 64'(busy_n), 64'd32);
        check({name, " ciphertext"}, ct, exp);
        check({name, " busy_trig_done"}, 64'(bad), 64'd0);
        tick();
        sample(kw, ct, b, d, t);
        check({name, " done_pulse"}, 64'(d), 64'd0);
        check({name, " ct_hold"}, ct, exp);
    endtask

    vec_t vecs [5];

    initial begin
        logic [63:0]  ct, ct1, ct2;
        logic         b, d, t;
        logic [127:0] ka;
        logic [63:0]  pa;
        int           dones, first, second, tlow;

        vecs[0] = '{80,  128'h0,  64'h0,                 64'h5579C1387B228445};
        vecs[1] = '{80,  K80_ONES, 64'h0,                64'hE72C46C0F5945049};
        vecs[2] = '{80,  128'h0,  64'hFFFF_FFFF_FFFF_FFFF, 64'hA112FFC72F68417B};
        vecs[3] = '{80,  K80_ONES, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3333DCD3213210D2};
        vecs[4] = '{128, 128'h0,  64'h0,                 64'h96DB702A2E6900AF};

        reset = 1'b1;
        drive(80, 1'b0, '0, '0);
        drive(128, 1'b0, '0, '0);
        repeat (3) tick();
        sample(80, ct, b, d, t);
        check("reset80_ct", ct, 64'h0);
        check("reset80_flags", {61'h0, b, d, t}, 64'h0);
        sample(128, ct, b, d, t);
        check("reset128_ct", ct, 64'h0);
        check("reset128_flags", {61'h0, b, d, t}, 64'h0);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) run_one($sformatf("kat%0d", i), vecs[i].kw, vecs[i].key, vecs[i].pt, vecs[i].exp);

        for (int i = 0; i < 9; i++) begin
            int kwr;
            kwr = (i < 6) ? 80 : 128;
            ka  = {$urandom, $urandom, $urandom, $urandom};
            if (kwr == 80) ka[127:80] = '0;
            pa  = {$urandom, $urandom};
            run_one($sformatf("rand%0d", i), kwr, ka, pa, model(kwr, ka, pa));
        end

        // Restart attempt and input changes mid-run.
        ka = {48'h0, $urandom, $urandom, 16'(($urandom))};
        pa = {$urandom, $urandom};
        drive(80, 1'b1, ka, pa);
        tick();
        drive(80, 1'b0, ~ka, ~pa);
        dones = 0; first = -1; ct1 = '0;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            tick();
            sample(80, ct, b, d, t);
            if (d) begin
                dones++;
                if (first < 0) begin first = cyc; ct1 = ct; end
            end
            if (cyc == 9)  drive(80, 1'b1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
            if (cyc == 10) drive(80, 1'b0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
        end
        check("restart_done_count", 64'(dones), 64'd1);
        check("restart_latency", 64'(first), 64'd32);
        check("restart_ct", ct1, model(80, ka, pa));

        // Asynchronous reset in the middle of a run.
        drive(80, 1'b1, K80_ONES, 64'h0123_4567_89AB_CDEF);
        tick();
        drive(80, 1'b0, '0, '0);
        repeat (14) tick();
        sample(80, ct, b, d, t);
        check("pre_reset_busy", 64'(b), 64'd1);
        reset = 1'b1;
        #1;
        sample(80, ct, b, d, t);
        check("midreset_flags", {61'h0, b, d, t}, 64'h0);
        check("midreset_ct", ct, 64'h0);
        tick();
        reset = 1'b0;
        tick();
        run_one("post_reset", 80, 128'h0, 64'h0, 64'h5579C1387B228445);

        // start held high: back-to-back runs.
        drive(80, 1'b1, 128'h0, 64'h0);
        tick();
        drive(80, 1'b1, K80_ONES, 64'hFFFF_FFFF_FFFF_FFFF);
        first = -1; second = -1; tlow = 0; ct1 = '0; ct2 = '0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            tick();
            sample(80, ct, b, d, t);
            if (cyc == 33) drive(80, 1'b0, '0, '0);
            if (d) begin
                if (first < 0) begin first = cyc; ct1 = ct; end
                else if (second < 0) begin second = cyc; ct2 = ct; end
            end
            if (!t && cyc < 65) tlow++;
        end
        check("b2b_first_done", 64'(first), 64'd32);
        check("b2b_second_done", 64'(second), 64'd65);
        check("b2b_ct1", ct1, 64'h5579C1387B228445);
        check("b2b_ct2", ct2, 64'h3333DCD3213210D2);
        check("b2b_trigger_gap", 64'(tlow), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end
endmodule
